// File: rtl/quiz_referee_pkg.sv
// Shared types and constants for the quiz referee: FSM state encoding,
// winner encoding and the index of the final question.
`timescale 1ns/1ps
package quiz_referee_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHOW  = 3'd1,
    S_WAIT  = 3'd2,
    S_JUDGE = 3'd3,
    S_NEXT  = 3'd4,
    S_OVER  = 3'd5
  } fsm_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } winner_t;

  localparam logic [2:0] LAST_QUESTION = 3'd5;

endpackage

// File: rtl/quiz_referee_if.sv
// Player/host-facing signal bundle of the quiz referee.
// Handshake: start/p1_go/p2_go are level buttons (one press per rising edge,
// no ready); trig_p1/trig_p2 are one-cycle pulses with no back-pressure.
`timescale 1ns/1ps
interface quiz_referee_if;
  logic       start;
  logic       p1_go;
  logic       p2_go;
  logic [2:0] p1_sel;
  logic [2:0] p2_sel;
  logic [2:0] ans;
  logic [2:0] state;
  logic       trig_p1;
  logic       trig_p2;
  logic       show_en;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] fsm;

  modport master (
    output start, p1_go, p2_go, p1_sel, p2_sel, ans,
    input  state, trig_p1, trig_p2, show_en, game_over, winner, fsm
  );

  modport slave (
    input  start, p1_go, p2_go, p1_sel, p2_sel, ans,
    output state, trig_p1, trig_p2, show_en, game_over, winner, fsm
  );
endinterface

// File: rtl/quiz_referee_btn_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector: a held button yields a single one-cycle pulse.
`timescale 1ns/1ps
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/quiz_referee.sv
// Two-player quiz referee: shows each question, accepts the first answers,
// judges them, pulses the score triggers and declares the winner.
`timescale 1ns/1ps
module quiz_referee
  import quiz_referee_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int WIN_SCORE      = 5
) (
  input logic           clk,
  input logic           rst,
  quiz_referee_if.slave bus
);

  localparam int CNT_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [2:0] WIN_Q = 3'(WIN_SCORE);

  fsm_t cur, nxt;

  logic          start_e, p1_e, p2_e;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic [2:0]    q;
  logic [2:0]    score1, score2;
  logic          lock1, lock2;
  logic          att1, att2;
  logic [2:0]    sel1, sel2;
  logic          trig1, trig2;

  logic acc1, acc2, c1, c2, w1, w2, timeout, show_done, game_end;

  btn_edge u_start (.clk(clk), .rst(rst), .din(bus.start), .pulse(start_e));
  btn_edge u_p1    (.clk(clk), .rst(rst), .din(bus.p1_go), .pulse(p1_e));
  btn_edge u_p2    (.clk(clk), .rst(rst), .din(bus.p2_go), .pulse(p2_e));

  // Go pulses only matter in WAIT; elsewhere they simply expire.
  assign acc1      = (cur == S_WAIT) && p1_e && !lock1;
  assign acc2      = (cur == S_WAIT) && p2_e && !lock2;
  assign c1        = att1 && (sel1 == bus.ans);
  assign c2        = att2 && (sel2 == bus.ans);
  assign w1        = att1 && !c1;
  assign w2        = att2 && !c2;
  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign show_done = (cnt == CW'(SHOW_CYCLES - 1));
  assign game_end  = (score1 >= WIN_Q) || (score2 >= WIN_Q) || (q >= LAST_QUESTION);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start_e) nxt = S_SHOW;
      S_SHOW:  if (show_done) nxt = S_WAIT;
      S_WAIT: begin
        if (acc1 || acc2) nxt = S_JUDGE;
        else if (timeout) nxt = S_NEXT;
      end
      S_JUDGE: begin
        if (c1 || c2)                             nxt = S_NEXT;
        else if ((lock1 || w1) && (lock2 || w2))  nxt = S_NEXT;
        else                                      nxt = S_WAIT;
      end
      S_NEXT:  nxt = game_end ? S_OVER : S_SHOW;
      S_OVER:  if (start_e) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.show_en   = (cur == S_SHOW) || (cur == S_WAIT) || (cur == S_JUDGE);
    bus.game_over = (cur == S_OVER);
    bus.winner    = WIN_NONE;
    if (cur == S_OVER) begin
      if (score1 > score2)      bus.winner = WIN_P1;
      else if (score2 > score1) bus.winner = WIN_P2;
      else                      bus.winner = WIN_TIE;
    end
  end

  assign bus.state   = q;
  assign bus.trig_p1 = trig1;
  assign bus.trig_p2 = trig2;
  assign bus.fsm     = cur;

  // The timeout count survives JUDGE->WAIT so a wrong answer buys no extra time.
  assign cnt_clr = (cur == S_IDLE) || (cur == S_NEXT) || (cur == S_SHOW && nxt == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cnt <= '0;
    else if (cnt_clr)                        cnt <= '0;
    else if (cur == S_SHOW || cur == S_WAIT) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      score1 <= '0;
      score2 <= '0;
      lock1  <= 1'b0;
      lock2  <= 1'b0;
      att1   <= 1'b0;
      att2   <= 1'b0;
      sel1   <= '0;
      sel2   <= '0;
      trig1  <= 1'b0;
      trig2  <= 1'b0;
    end else begin
      trig1 <= 1'b0;
      trig2 <= 1'b0;
      case (cur)
        S_IDLE: begin
          q      <= '0;
          score1 <= '0;
          score2 <= '0;
          lock1  <= 1'b0;
          lock2  <= 1'b0;
        end
        S_WAIT: begin
          att1 <= acc1;
          att2 <= acc2;
          if (acc1) sel1 <= bus.p1_sel;
          if (acc2) sel2 <= bus.p2_sel;
        end
        S_JUDGE: begin
          trig1 <= c1;
          trig2 <= c2;
          if (c1 && score1 != WIN_Q) score1 <= score1 + 3'd1;
          if (c2 && score2 != WIN_Q) score2 <= score2 + 3'd1;
          lock1 <= lock1 | w1;
          lock2 <= lock2 | w2;
        end
        S_NEXT: begin
          lock1 <= 1'b0;
          lock2 <= 1'b0;
          if (!game_end) q <= q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_referee.sv
// Directed testbench for quiz_referee: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_quiz_referee;
  import quiz_referee_pkg::*;

  localparam int SHOW_C = 8;
  localparam int TO_C   = 40;
  localparam int WIN_C  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quiz_referee_if bus();

  quiz_referee #(.SHOW_CYCLES(SHOW_C), .TIMEOUT_CYCLES(TO_C), .WIN_SCORE(WIN_C)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n1 = 0;
  int n2 = 0;

  always @(negedge clk) begin
    if (bus.trig_p1 === 1'b1) n1++;
    if (bus.trig_p2 === 1'b1) n2++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start = 1'b0; bus.p1_go = 1'b0; bus.p2_go = 1'b0;
    bus.p1_sel = 3'd0; bus.p2_sel = 3'd0; bus.ans = 3'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    cycles(3);
    bus.start = 1'b0;
    cycles(1);
  endtask

  task automatic wait_fsm(input logic [2:0] target, input int budget, output bit ok);
    int i;
    i = 0;
    while (bus.fsm !== target && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (bus.fsm === target);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycles(2);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
    checks++; if (bus.trig_p1 !== 1'b0 || bus.trig_p2 !== 1'b0) begin errors++; $display("FAIL rst_trig got %b%b exp 00", bus.trig_p1, bus.trig_p2); end
    checks++; if (bus.show_en !== 1'b0) begin errors++; $display("FAIL rst_show_en got %b exp 0", bus.show_en); end
    checks++; if (bus.game_over !== 1'b0 || bus.winner !== 2'd0) begin errors++; $display("FAIL rst_over got %b/%0d exp 0/0", bus.game_over, bus.winner); end
    rst = 1'b0;
    cycles(6);
    checks++; if (bus.fsm !== S_IDLE || bus.show_en !== 1'b0) begin errors++; $display("FAIL idle_hold got fsm %0d show %b exp 0/0", bus.fsm, bus.show_en); end
  endtask

  task automatic test_single_correct();
    bit ok;
    int b1, b2;
    apply_reset();
    bus.ans = 3'd1;
    press_start();
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL q0_wait_timeout got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    checks++; if (bus.show_en !== 1'b1 || bus.state !== 3'd0) begin errors++; $display("FAIL q0_wait_outputs got show %b state %0d exp 1/0", bus.show_en, bus.state); end
    b1 = n1; b2 = n2;
    bus.p1_sel = 3'd1;
    bus.p1_go = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycles(1);
      if (k == 3) bus.p1_go = 1'b0;
      checks++;
      if (bus.trig_p1 !== (k == 5)) begin errors++; $display("FAIL p1_latency_c%0d got %b exp %b", k, bus.trig_p1, (k == 5)); end
    end
    cycles(1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL q0_advance got %0d exp 1", bus.state); end
    checks++; if (n1 - b1 != 1 || n2 - b2 != 0) begin errors++; $display("FAIL q0_pulse_count got %0d/%0d exp 1/0", n1 - b1, n2 - b2); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int b1, b2;
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL q1_wait_timeout got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    b1 = n1; b2 = n2;
    bus.ans = 3'd2; bus.p1_sel = 3'd3; bus.p2_sel = 3'd2;
    bus.p1_go = 1'b1; bus.p2_go = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycles(1);
      if (k == 3) begin bus.p1_go = 1'b0; bus.p2_go = 1'b0; end
      checks++;
      if (bus.trig_p2 !== (k == 5) || bus.trig_p1 !== 1'b0) begin errors++; $display("FAIL both_press_c%0d got p1 %b p2 %b exp 0 %b", k, bus.trig_p1, bus.trig_p2, (k == 5)); end
    end
    cycles(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL q1_advance got %0d exp 2", bus.state); end
    checks++; if (n1 - b1 != 0 || n2 - b2 != 1) begin errors++; $display("FAIL q1_pulse_count got %0d/%0d exp 0/1", n1 - b1, n2 - b2); end
  endtask

  task automatic test_lockout();
    bit ok;
    int b1, b2;
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL q2_wait_timeout got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    b1 = n1; b2 = n2;
    bus.ans = 3'd4; bus.p1_sel = 3'd6;
    bus.p1_go = 1'b1; cycles(3); bus.p1_go = 1'b0; cycles(4);
    checks++; if (bus.fsm !== S_WAIT || bus.state !== 3'd2) begin errors++; $display("FAIL wrong_back_to_wait got fsm %0d state %0d exp %0d/2", bus.fsm, bus.state, S_WAIT); end
    bus.p1_sel = 3'd4;
    bus.p1_go = 1'b1; cycles(3); bus.p1_go = 1'b0; cycles(6);
    checks++; if (n1 - b1 != 0 || bus.fsm !== S_WAIT) begin errors++; $display("FAIL locked_p1_ignored got pulses %0d fsm %0d exp 0/%0d", n1 - b1, bus.fsm, S_WAIT); end
    bus.p2_sel = 3'd4;
    bus.p2_go = 1'b1; cycles(3); bus.p2_go = 1'b0; cycles(4);
    checks++; if (n2 - b2 != 1 || bus.state !== 3'd3) begin errors++; $display("FAIL p2_after_lock got pulses %0d state %0d exp 1/3", n2 - b2, bus.state); end
    // Both players wrong: question skipped long before the timeout.
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL q3_wait_timeout got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    b1 = n1; b2 = n2;
    bus.ans = 3'd7; bus.p1_sel = 3'd0; bus.p2_sel = 3'd1;
    bus.p1_go = 1'b1; bus.p2_go = 1'b1; cycles(3);
    bus.p1_go = 1'b0; bus.p2_go = 1'b0; cycles(4);
    checks++; if (bus.state !== 3'd4 || n1 - b1 != 0 || n2 - b2 != 0) begin errors++; $display("FAIL both_locked_skip got state %0d pulses %0d/%0d exp 4 0/0", bus.state, n1 - b1, n2 - b2); end
  endtask

  task automatic test_timeout();
    bit ok;
    int b1, b2;
    apply_reset();
    b1 = n1; b2 = n2;
    press_start();
    wait_fsm(S_OVER, 6 * (SHOW_C + TO_C + 5) + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_game_end got fsm %0d exp %0d", bus.fsm, S_OVER); end
    cycles(1);
    checks++; if (n1 - b1 != 0 || n2 - b2 != 0) begin errors++; $display("FAIL timeout_no_trig got %0d/%0d exp 0/0", n1 - b1, n2 - b2); end
    checks++; if (bus.game_over !== 1'b1 || bus.winner !== 2'd3) begin errors++; $display("FAIL tie_result got over %b winner %0d exp 1/3", bus.game_over, bus.winner); end
    checks++; if (bus.show_en !== 1'b0 || bus.state !== 3'd5) begin errors++; $display("FAIL over_outputs got show %b state %0d exp 0/5", bus.show_en, bus.state); end
  endtask

  task automatic test_win();
    bit ok;
    int b1;
    apply_reset();
    b1 = n1;
    press_start();
    for (int r = 0; r < 5; r++) begin
      wait_fsm(S_WAIT, SHOW_C + 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL win_r%0d_wait got fsm %0d exp %0d", r, bus.fsm, S_WAIT); end
      bus.ans = 3'(r + 2); bus.p1_sel = 3'(r + 2);
      bus.p1_go = 1'b1;
      cycles(3); bus.p1_go = 1'b0; cycles(2);
      checks++; if (bus.trig_p1 !== 1'b1) begin errors++; $display("FAIL win_r%0d_trig got %b exp 1", r, bus.trig_p1); end
      cycles(2);
      checks++; if (bus.game_over !== (r == 4)) begin errors++; $display("FAIL win_r%0d_over got %b exp %b", r, bus.game_over, (r == 4)); end
    end
    checks++; if (bus.winner !== 2'd1 || bus.state !== 3'd4) begin errors++; $display("FAIL p1_wins got winner %0d state %0d exp 1/4", bus.winner, bus.state); end
    bus.p1_go = 1'b1; cycles(3); bus.p1_go = 1'b0; cycles(8);
    checks++; if (n1 - b1 != 5 || bus.fsm !== S_OVER) begin errors++; $display("FAIL over_no_trig got pulses %0d fsm %0d exp 5/%0d", n1 - b1, bus.fsm, S_OVER); end
  endtask

  task automatic test_reset_in_judge();
    bit ok;
    int b1;
    apply_reset();
    bus.ans = 3'd3;
    press_start();
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rj_wait got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    b1 = n1;
    bus.p1_sel = 3'd3; bus.p1_go = 1'b1;
    cycles(3); bus.p1_go = 1'b0; cycles(1);
    checks++; if (bus.fsm !== S_JUDGE) begin errors++; $display("FAIL rj_in_judge got fsm %0d exp %0d", bus.fsm, S_JUDGE); end
    rst = 1'b1;
    #1;
    checks++; if (bus.trig_p1 !== 1'b0 || bus.show_en !== 1'b0 || bus.state !== 3'd0 || bus.game_over !== 1'b0 || bus.winner !== 2'd0) begin errors++; $display("FAIL rj_outputs_zero got trig %b show %b state %0d over %b win %0d exp all 0", bus.trig_p1, bus.show_en, bus.state, bus.game_over, bus.winner); end
    cycles(3);
    rst = 1'b0;
    cycles(10);
    checks++; if (n1 - b1 != 0 || bus.fsm !== S_IDLE) begin errors++; $display("FAIL rj_no_trig got pulses %0d fsm %0d exp 0/%0d", n1 - b1, bus.fsm, S_IDLE); end
  endtask

  task automatic test_held_go();
    bit ok;
    int b1, b2;
    apply_reset();
    bus.ans = 3'd5;
    press_start();
    wait_fsm(S_WAIT, SHOW_C + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_wait got fsm %0d exp %0d", bus.fsm, S_WAIT); end
    b1 = n1; b2 = n2;
    bus.p1_sel = 3'd5; bus.p1_go = 1'b1;
    cycles(100);
    bus.p1_go = 1'b0;
    cycles(3);
    checks++; if (n1 - b1 != 1 || n2 - b2 != 0) begin errors++; $display("FAIL held_one_press got %0d/%0d exp 1/0", n1 - b1, n2 - b2); end
  endtask

  initial begin
    test_reset();
    test_single_correct();
    test_simultaneous();
    test_lockout();
    test_timeout();
    test_win();
    test_reset_in_judge();
    test_held_go();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
